wm_challenge: RTL and testbench

Wake-up challenge responder for the alarm clock's wake-mode state machine. It consumes that controller's control strobes: new-puzzle request, timer enable/reset, score count/reset/freeze. It returns the status that drives its transitions:
- `done` — puzzle closed
- `right` — correct answer
- `threshold` — enough correct answers to silence the alarm

It holds a free-running LFSR, the current target value shown to the user, a per-puzzle countdown timer and a saturating score counter.

---
 rtl/wm_challenge.sv | 142 ++++++++++++++
 tb/tb_wm_challenge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_challenge.sv
`default_nettype none
// ============================================================================
// Module   : wm_challenge
// Purpose  : Wake-up challenge responder for the alarm clock's wake-mode
//            controller. Holds a free-running 8-bit LFSR, the displayed puzzle
//            target, a per-puzzle seconds countdown and a saturating score.
//            Reports done / right / threshold back to the controller.
// Ports    : clk, reset (sync, active-high)
//            RNG                          - load a new target from the LFSR
//            timer_enable / timer_reset   - run / reload the puzzle countdown
//            count / count_reset / count_stop - score increment / clear / freeze
//            guess[WIDTH], submit         - user switches and debounced button
//            target[WIDTH], secs_left[8], score[8] - display values
//            done, right (sticky), threshold (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module wm_challenge #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int TIMEOUT_S = 10,
  parameter int GOAL      = 3,
  parameter int WIDTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RNG,
  input  logic             timer_enable,
  input  logic             timer_reset,
  input  logic             count,
  input  logic             count_reset,
  input  logic             count_stop,
  input  logic [WIDTH-1:0] guess,
  input  logic             submit,
  output logic [WIDTH-1:0] target,
  output logic [7:0]       secs_left,
  output logic [7:0]       score,
  output logic             done,
  output logic             right,
  output logic             threshold
);

  localparam int         TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_S);
  localparam logic [7:0] C_GOAL    = 8'(GOAL);
  localparam logic [7:0] C_SEED    = 8'hA5;

  logic [7:0]       lfsr_q,   lfsr_d;
  logic             sub_q;
  logic [TW-1:0]    tick_q,   tick_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [7:0]       secs_q,   secs_d;
  logic [7:0]       score_q,  score_d;
  logic             done_q,   done_d;
  logic             right_q,  right_d;

  logic             sub_edge;
  logic [WIDTH-1:0] cand;

  assign sub_edge = submit & ~sub_q;
  assign cand     = lfsr_q[WIDTH-1:0];

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // New target always differs from the previous one.
  always_comb begin
    target_d = target_q;
    if (RNG) begin
      target_d = (cand == target_q) ? (cand ^ WIDTH'(1)) : cand;
    end
  end

  always_comb begin
    tick_d  = tick_q;
    secs_d  = secs_q;
    done_d  = done_q;
    right_d = right_q;
    if (timer_reset) begin
      tick_d  = '0;
      secs_d  = C_TIMEOUT;
      done_d  = 1'b0;
      right_d = 1'b0;
    end else if (timer_enable && !done_q) begin
      if (sub_edge) begin
        // A submission beats a coinciding final tick; the timer stops here.
        done_d  = 1'b1;
        right_d = (guess == target_q);
      end else if (tick_q == C_TICK_LAST) begin
        tick_d = '0;
        secs_d = secs_q - 8'd1;
        if (secs_q == 8'd1) begin
          done_d  = 1'b1;
          right_d = 1'b0;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // Score next-state also feeds threshold, so reset is folded in here.
  always_comb begin
    score_d = score_q;
    if (reset || count_reset) begin
      score_d = 8'd0;
    end else if (count && !count_stop) begin
      score_d = (score_q >= C_GOAL) ? C_GOAL : (score_q + 8'd1);
    end
  end

  assign threshold = (score_d >= C_GOAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= C_SEED;
      sub_q    <= 1'b1;    // button held through reset yields no edge
      tick_q   <= '0;
      target_q <= '0;
      secs_q   <= C_TIMEOUT;
      score_q  <= 8'd0;
      done_q   <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      sub_q    <= submit;
      tick_q   <= tick_d;
      target_q <= target_d;
      secs_q   <= secs_d;
      score_q  <= score_d;
      done_q   <= done_d;
      right_q  <= right_d;
    end
  end

  assign target    = target_q;
  assign secs_left = secs_q;
  assign score     = score_q;
  assign done      = done_q;
  assign right     = right_q;

endmodule
`default_nettype wire

// File: tb/tb_wm_challenge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_challenge
// Purpose  : Directed self-checking bench for wm_challenge with
//            TICK_DIV=4, TIMEOUT_S=3, GOAL=2, WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wm_challenge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RNG = 1'b0;
  logic       timer_enable = 1'b0;
  logic       timer_reset = 1'b0;
  logic       count = 1'b0;
  logic       count_reset = 1'b0;
  logic       count_stop = 1'b0;
  logic [3:0] guess = 4'd0;
  logic       submit = 1'b0;
  logic [3:0] target;
  logic [7:0] secs_left;
  logic [7:0] score;
  logic       done;
  logic       right;
  logic       threshold;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_lfsr;      // reference LFSR
  logic [3:0] exp_target;  // reference target

  wm_challenge #(
    .TICK_DIV (4),
    .TIMEOUT_S(3),
    .GOAL     (2),
    .WIDTH    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RNG         (RNG),
    .timer_enable(timer_enable),
    .timer_reset (timer_reset),
    .count       (count),
    .count_reset (count_reset),
    .count_stop  (count_stop),
    .guess       (guess),
    .submit      (submit),
    .target      (target),
    .secs_left   (secs_left),
    .score       (score),
    .done        (done),
    .right       (right),
    .threshold   (threshold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Advance n edges and land 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One RNG pulse together with timer_reset; updates the target model.
  task automatic new_puzzle();
    logic [3:0] c;
    c = m_lfsr[3:0];
    exp_target = (c == exp_target) ? (c ^ 4'd1) : c;
    RNG = 1'b1; timer_reset = 1'b1; timer_enable = 1'b0;
    cyc(1);
    RNG = 1'b0; timer_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; submit = 1'b1; exp_target = 4'd0;
    cyc(2);
    checks++; if (target !== 4'd0)   begin errors++; $display("FAIL reset_target got %0d want 0", target); end
    checks++; if (secs_left !== 8'd3) begin errors++; $display("FAIL reset_secs got %0d want 3", secs_left); end
    checks++; if (score !== 8'd0)    begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    checks++; if ({done, right, threshold} !== 3'b000)
      begin errors++; $display("FAIL reset_flags got %b want 000", {done, right, threshold}); end
    reset = 1'b0; timer_enable = 1'b1;
    cyc(2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL held_submit_no_edge done=%b want 0", done); end
    timer_enable = 1'b0; submit = 1'b0;
    cyc(1);
  endtask

  task automatic test_correct();
    new_puzzle();
    checks++; if (target !== exp_target)
      begin errors++; $display("FAIL rng_target got %h want %h", target, exp_target); end
    checks++; if (secs_left !== 8'd3) begin errors++; $display("FAIL treset_secs got %0d want 3", secs_left); end
    timer_enable = 1'b1; guess = exp_target; submit = 1'b1;
    cyc(1);
    checks++; if ({done, right} !== 2'b11)
      begin errors++; $display("FAIL correct_done_right got %b want 11", {done, right}); end
    submit = 1'b0; guess = exp_target ^ 4'd1;
    cyc(1);
    submit = 1'b1;
    cyc(3);
    checks++; if ({done, right} !== 2'b11)
      begin errors++; $display("FAIL second_edge_ignored got %b want 11", {done, right}); end
    checks++; if (secs_left !== 8'd3)
      begin errors++; $display("FAIL frozen_secs got %0d want 3", secs_left); end
    submit = 1'b0; timer_enable = 1'b0;
    cyc(1);
  endtask

  task automatic test_timeout_reroll();
    logic [3:0] old;
    bit found;
    timer_reset = 1'b1;
    cyc(1);
    timer_reset = 1'b0; timer_enable = 1'b1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL treset_clears_done got %b want 0", done); end
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      checks++; if (secs_left !== 8'(3 - i / 4))
        begin errors++; $display("FAIL countdown_%0d secs got %0d want %0d", i, secs_left, 3 - i / 4); end
      checks++; if (done !== (i == 12))
        begin errors++; $display("FAIL countdown_done_%0d got %b want %b", i, done, (i == 12)); end
    end
    checks++; if (right !== 1'b0) begin errors++; $display("FAIL timeout_right got %b want 0", right); end
    cyc(3);
    checks++; if (secs_left !== 8'd0 || done !== 1'b1)
      begin errors++; $display("FAIL timeout_hold secs=%0d done=%b want 0/1", secs_left, done); end
    timer_enable = 1'b0;
    // Wait for the LFSR low nibble to collide with the current target.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_lfsr[3:0] == exp_target) found = 1'b1;
      else cyc(1);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reroll_collision_wait timed out want lfsr nibble %h", exp_target);
    end else begin
      old = exp_target;
      RNG = 1'b1;
      cyc(1);
      RNG = 1'b0;
      exp_target = old ^ 4'd1;
      if (target !== exp_target)
        begin errors++; $display("FAIL reroll_target got %h want %h", target, exp_target); end
    end
  endtask

  task automatic test_final_tick_submit();
    timer_reset = 1'b1;
    cyc(1);
    timer_reset = 1'b0; timer_enable = 1'b1; guess = exp_target; submit = 1'b0;
    cyc(11);
    checks++; if (secs_left !== 8'd1 || done !== 1'b0)
      begin errors++; $display("FAIL pre_final secs=%0d done=%b want 1/0", secs_left, done); end
    submit = 1'b1;
    cyc(1);
    checks++; if ({done, right} !== 2'b11)
      begin errors++; $display("FAIL final_tick_submit got %b want 11", {done, right}); end
    checks++; if (secs_left !== 8'd1)
      begin errors++; $display("FAIL final_tick_secs got %0d want 1", secs_left); end
    submit = 1'b0; timer_enable = 1'b0;
    cyc(1);
  endtask

  task automatic test_score();
    count_reset = 1'b1;
    cyc(1);
    count_reset = 1'b0; count = 1'b1;
    #1;
    checks++; if (threshold !== 1'b0) begin errors++; $display("FAIL thr_from0 got %b want 0", threshold); end
    cyc(1);
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL score_1 got %0d want 1", score); end
    #1;
    checks++; if (threshold !== 1'b1) begin errors++; $display("FAIL thr_comb got %b want 1", threshold); end
    cyc(1);
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL score_2 got %0d want 2", score); end
    cyc(2);
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL score_sat got %0d want 2", score); end
    count_reset = 1'b1;
    #1;
    checks++; if (threshold !== 1'b0) begin errors++; $display("FAIL thr_creset got %b want 0", threshold); end
    cyc(1);
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL score_creset got %0d want 0", score); end
    count_reset = 1'b0; count_stop = 1'b1;
    #1;
    checks++; if (threshold !== 1'b0) begin errors++; $display("FAIL thr_stop got %b want 0", threshold); end
    cyc(2);
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL score_stop got %0d want 0", score); end
    count = 1'b0; count_stop = 1'b0;
    cyc(1);
  endtask

  task automatic test_back_to_back();
    bit ok_ans[3] = '{1'b0, 1'b1, 1'b1};
    count_reset = 1'b1;
    cyc(1);
    count_reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      new_puzzle();
      checks++; if (done !== 1'b0 || target !== exp_target)
        begin errors++; $display("FAIL loop%0d_rearm done=%b target=%h want 0/%h", r, done, target, exp_target); end
      timer_enable = 1'b1;
      guess = ok_ans[r] ? exp_target : (exp_target ^ 4'd1);
      cyc(1);
      submit = 1'b1;
      cyc(1);
      submit = 1'b0; timer_enable = 1'b0;
      cyc(2);
      checks++; if ({done, right} !== {1'b1, ok_ans[r]})
        begin errors++; $display("FAIL loop%0d_result got %b want %b", r, {done, right}, {1'b1, ok_ans[r]}); end
      if (ok_ans[r]) begin
        count = 1'b1;
        #1;
        checks++; if (threshold !== (r == 2))
          begin errors++; $display("FAIL loop%0d_threshold got %b want %b", r, threshold, (r == 2)); end
        cyc(1);
        count = 1'b0;
      end
    end
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL loop_score got %0d want 2", score); end
  endtask

  task automatic test_mid_reset();
    timer_reset = 1'b1;
    cyc(1);
    timer_reset = 1'b0; timer_enable = 1'b1; count = 1'b1; RNG = 1'b1;
    cyc(5);
    reset = 1'b1;
    cyc(1);
    checks++; if (target !== 4'd0 || secs_left !== 8'd3 || score !== 8'd0 || done !== 1'b0)
      begin errors++; $display("FAIL mid_reset target=%h secs=%0d score=%0d done=%b want 0/3/0/0",
                               target, secs_left, score, done); end
    reset = 1'b0; timer_enable = 1'b0; count = 1'b0; RNG = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_correct();
    test_timeout_reroll();
    test_final_tick_submit();
    test_score();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
